// File: rtl/ps2_key_serializer.sv
// ---------------------------------------------------------------------------
// ps2_key_serializer
//
// Turns MiSTer hps_io ps2_key event words into a device-side PS/2 serial
// stream. Each event becomes one to three bytes: E0 if extended, F0 if
// released, then the scancode. The bytes go into a small FIFO, so bursts of
// events survive while earlier frames are still being shifted out. Each byte
// is sent as an 11-bit frame: start 0, D0..D7 LSB first, odd parity, stop 1.
// Data changes while the clock is high, and the receiver samples it on the
// falling edge of ps2_clk.
//
// Ports:
//   clk_sys     in   system clock
//   reset_n     in   asynchronous active-low reset
//   ps2_key     in   [10] toggles per event, [9] pressed, [8] extended,
//                    [7:0] scancode
//   enable      in   1 = a new frame may start
//   ps2_clk     out  PS/2 clock, idle high
//   ps2_data    out  PS/2 data, idle high
//   busy        out  frame or gap in progress, FIFO non-empty, or event
//                    bytes still being queued
//   overflow    out  sticky: an event was dropped because the FIFO was full
//   fifo_level  out  number of bytes currently queued
// ---------------------------------------------------------------------------
module ps2_key_serializer #(
   parameter int CLK_HZ     = 28636360,
   parameter int PS2_HZ     = 12000,
   parameter int FIFO_DEPTH = 16,
   parameter int GAP_BITS   = 2
) (
   input  logic                          clk_sys,
   input  logic                          reset_n,
   input  logic [10:0]                   ps2_key,
   input  logic                          enable,
   output logic                          ps2_clk,
   output logic                          ps2_data,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int GAP_CYC = GAP_BITS * 2 * HALF;
   // The lines are high during the GAP state and also during the IDLE and
   // LOAD states that follow it. GAP is two cycles shorter than the nominal
   // gap, so that back-to-back frame starts are exactly
   // (22 + 2*GAP_BITS)*HALF cycles apart.
   localparam int GAP_LEN = (GAP_CYC > 2) ? (GAP_CYC - 2) : 1;
   localparam int TMR_MAX = (HALF > GAP_LEN) ? HALF : GAP_LEN;
   localparam int TW      = $clog2(TMR_MAX + 1);

   localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
   localparam logic [TW-1:0] GAP_M1  = TW'(GAP_LEN - 1);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Event sequencer
   // ------------------------------------------------------------------
   logic          r_armed;
   logic          r_last_tog;
   logic          r_seq_active;
   logic [23:0]   r_seq_bytes;    // next byte to push is always in [7:0]
   logic [1:0]    r_seq_left;
   logic          r_overflow;

   logic          w_toggle;
   logic [1:0]    w_needed;
   logic [23:0]   w_bytes;
   logic [AW:0]   w_free;
   logic          w_fits;
   logic          w_push;

   logic [AW:0]   r_level;

   // Toggles are ignored until the reference value has been captured and
   // while a previous event is still being queued.
   assign w_toggle = r_armed && !r_seq_active && (ps2_key[10] != r_last_tog);

   // Bytes are packed in transmit order, starting at the low byte.
   always_comb begin
      w_needed = 2'd1;
      w_bytes  = {16'h0000, ps2_key[7:0]};
      case ({ps2_key[8], ps2_key[9]})
         2'b01: begin   // plain make
            w_needed = 2'd1;
            w_bytes  = {16'h0000, ps2_key[7:0]};
         end
         2'b00: begin   // plain break
            w_needed = 2'd2;
            w_bytes  = {8'h00, ps2_key[7:0], 8'hF0};
         end
         2'b11: begin   // extended make
            w_needed = 2'd2;
            w_bytes  = {8'h00, ps2_key[7:0], 8'hE0};
         end
         default: begin // extended break
            w_needed = 2'd3;
            w_bytes  = {ps2_key[7:0], 8'hF0, 8'hE0};
         end
      endcase
   end

   // Pops can only add room while a sequence is being pushed. Checking the
   // free space once, at acceptance, is therefore enough to never overfill.
   assign w_free = DEPTH_W - r_level;
   assign w_fits = (w_free >= (AW + 1)'(w_needed));
   assign w_push = r_seq_active;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_armed      <= 1'b0;
         r_last_tog   <= 1'b0;
         r_seq_active <= 1'b0;
         r_seq_bytes  <= 24'h000000;
         r_seq_left   <= 2'd0;
         r_overflow   <= 1'b0;
      end else begin
         if (!r_armed) begin
            // The first cycle after reset only learns the current toggle
            // state, so a key word that is already present does not send.
            r_armed    <= 1'b1;
            r_last_tog <= ps2_key[10];
         end else if (w_toggle) begin
            r_last_tog <= ps2_key[10];
            if (w_fits) begin
               r_seq_active <= 1'b1;
               r_seq_bytes  <= w_bytes;
               r_seq_left   <= w_needed;
            end else begin
               r_overflow <= 1'b1;
            end
         end else if (r_seq_active) begin
            r_seq_bytes <= {8'h00, r_seq_bytes[23:8]};
            r_seq_left  <= r_seq_left - 2'd1;
            if (r_seq_left == 2'd1) begin
               r_seq_active <= 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Byte FIFO (power-of-two depth, so the pointers wrap naturally)
   // ------------------------------------------------------------------
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [7:0]    w_rd_byte;
   logic          w_pop;

   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= r_seq_bytes[7:0];
      end
   end

   assign w_rd_byte = r_mem[r_rd_ptr];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Serializer FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BIT_HI,
      S_BIT_LO,
      S_GAP
   } state_t;

   state_t        r_state, w_state_next;
   logic [TW-1:0] r_tmr, w_tmr_next;
   logic [3:0]    r_bit, w_bit_next;       // index of the bit on the wire
   logic [10:0]   r_frame, w_frame_next;   // current bit is always [0]
   logic          r_clk_out, w_clk_next;
   logic          r_data_out, w_data_next;

   // The line values are registered together with the state, so both pins
   // are glitch-free and always match the state they belong to.
   always_comb begin
      w_state_next = r_state;
      w_tmr_next   = r_tmr;
      w_bit_next   = r_bit;
      w_frame_next = r_frame;
      w_clk_next   = 1'b1;
      w_data_next  = 1'b1;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((r_level != '0) && enable) begin
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_pop        = 1'b1;
            w_frame_next = {1'b1, ~^w_rd_byte, w_rd_byte, 1'b0};
            w_bit_next   = 4'd0;
            w_tmr_next   = HALF_M1;
            w_data_next  = 1'b0;   // start bit appears with the clock high
            w_state_next = S_BIT_HI;
         end
         S_BIT_HI: begin
            w_data_next = r_frame[0];
            if (r_tmr == '0) begin
               w_state_next = S_BIT_LO;
               w_tmr_next   = HALF_M1;
               w_clk_next   = 1'b0;
            end else begin
               w_tmr_next = r_tmr - 1'b1;
            end
         end
         S_BIT_LO: begin
            if (r_tmr != '0) begin
               w_tmr_next  = r_tmr - 1'b1;
               w_clk_next  = 1'b0;
               w_data_next = r_frame[0];
            end else if (r_bit == 4'd10) begin
               w_state_next = S_GAP;
               w_tmr_next   = GAP_M1;
            end else begin
               w_state_next = S_BIT_HI;
               w_tmr_next   = HALF_M1;
               w_bit_next   = r_bit + 4'd1;
               w_frame_next = {1'b1, r_frame[10:1]};
               w_data_next  = r_frame[1];
            end
         end
         S_GAP: begin
            if (r_tmr == '0) begin
               w_state_next = S_IDLE;
            end else begin
               w_tmr_next = r_tmr - 1'b1;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_tmr      <= '0;
         r_bit      <= 4'd0;
         r_frame    <= 11'h7FF;
         r_clk_out  <= 1'b1;
         r_data_out <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_tmr      <= w_tmr_next;
         r_bit      <= w_bit_next;
         r_frame    <= w_frame_next;
         r_clk_out  <= w_clk_next;
         r_data_out <= w_data_next;
      end
   end

   assign ps2_clk    = r_clk_out;
   assign ps2_data   = r_data_out;
   assign overflow   = r_overflow;
   assign fifo_level = r_level;
   assign busy       = (r_state != S_IDLE) || (r_level != '0) || r_seq_active;

endmodule

// File: doc/ps2_key_serializer.md
Name: ps2_key_serializer

Overview:
- Converts MiSTer hps_io `ps2_key` event words into a genuine PS/2 device-side serial stream (`ps2_clk` / `ps2_data`).
- Drives the PC-8001 core's PS/2 keyboard inputs, which the emu top level currently leaves unconnected.
- Generalises the fixed key hookup: clock rate, PS/2 bit rate, FIFO depth and inter-byte gap are all parameters.
- Buffers events in a FIFO, so bursts of key events are not lost while serial frames are in flight.

Parameters:
- CLK_HZ, 28636360, clk_sys frequency in Hz.
- PS2_HZ, 12000, PS/2 bit rate in Hz. HALF = CLK_HZ/(2*PS2_HZ), integer-truncated; default HALF = 1193.
- FIFO_DEPTH, 16, byte FIFO depth. Must be a power of two and ≥ 4.
- GAP_BITS, 2, idle bit periods inserted after each frame's stop bit.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_key  in  11  hps_io event word: [10] toggles per event, [9] pressed, [8] extended, [7:0] scancode
- enable  in  1  1 = serializer may start new frames
- ps2_clk  out  1  PS/2 clock, idle high
- ps2_data  out  1  PS/2 data, idle high
- busy  out  1  frame or gap in progress, or FIFO non-empty
- overflow  out  1  sticky flag: an event was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently queued

Behaviour:
- Reset values (async assert): `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0, `overflow` = 0, `fifo_level` = 0.
  - FIFO is emptied, serializer returns to IDLE, sequencer returns to idle.
  - Asserting reset mid-frame returns both lines high immediately; no partial frame resumes.
- Event capture:
  - `last_tog` is loaded from `ps2_key[10]` on the first clock after reset release. No event is generated on that cycle.
  - After that, when the sequencer is idle and `ps2_key[10]` != `last_tog`, latch the event and update `last_tog`.
  - Toggles that occur while the sequencer is busy are sampled once it becomes idle. Two toggles inside that window cancel and are lost; this is accepted behaviour.
- Byte sequence per event:
  - Order: E0 if [8]; then F0 if ![9]; then the code.
  - needed = 1 + [8] + ![9], range 1..3.
  - If FIFO free < needed: the whole event is dropped and `overflow` is set (cleared only by reset). Partial sequences are never queued.
  - Otherwise one byte is pushed per cycle, in order.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - Pop only when non-empty.
- Serializer FSM: IDLE → LOAD → (BIT_HI → BIT_LO) × 11 → GAP → IDLE.
  - IDLE: lines high. Go to LOAD when FIFO non-empty and `enable` = 1.
  - LOAD: pop a byte and form an 11-bit frame: start 0, D0..D7 (LSB first), odd parity (~^data), stop 1.
  - BIT_HI: `ps2_clk` = 1, `ps2_data` = current bit, for HALF cycles.
  - BIT_LO: `ps2_clk` = 0, data held, for HALF cycles. The receiver samples on the falling edge.
  - After the 11th BIT_LO, enter GAP: lines high for GAP_BITS×2×HALF cycles, then IDLE.
  - `enable` deasserted mid-frame does not abort the frame; it only blocks the next LOAD.
- Latency:
  - `ps2_data` goes low (start bit) ≤ 4 clk_sys cycles after the toggle edge, when the FIFO was empty and the serializer idle.
  - Frame length is 22×HALF cycles (26246 at defaults). Frame start to next frame start is (22+2×GAP_BITS)×HALF (31018 at defaults).
- `busy` = (state != IDLE) | (`fifo_level` != 0) | sequencer active.

Test Plan:
- Reset release with `ps2_key` = 11'h400 held → no frame emitted, `busy` stays 0 for 100000 cycles, both lines stay 1.
- Toggle [10] with pressed = 1, ext = 0, code 8'h1C → one frame. On falling edges, bits sample as 0, 0,0,1,1,1,0,0,0, parity 0, stop 1. Low phase is 1193 cycles, frame is 26246 cycles.
- Toggle with pressed = 0, ext = 1, code 8'h75 → frames E0, F0, 75 in that order. Parities are 0, 1, 0. Frame starts are spaced 31018 cycles apart. `fifo_level` peaks at 2.
- Twelve 3-byte events issued back-to-back with `enable` = 0, FIFO_DEPTH = 16 → first 5 events queued (`fifo_level` = 15). Events 6–12 are dropped, `overflow` = 1. Then set `enable` = 1 → exactly 15 frames emitted, FIFO drains to 0.
- Assert `reset_n` = 0 during the 5th data bit → `ps2_clk` = `ps2_data` = 1 and `fifo_level` = 0 asynchronously. After release, no stray frame appears.
- `enable` dropped mid-frame with 2 bytes queued → current frame completes. Lines stay idle with `fifo_level` = 2 until `enable` returns, then 2 frames follow.
